// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {OWN_INSTR = 1'b0, OWN_DATA = 1'b1} owner_e;

    localparam int MAX_OUTSTANDING_DEF = 2;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int CNT_W = cnt_w(MAX_OUTSTANDING_DEF);

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order owner-tag FIFO recording which port issued each in-flight request.
// DEPTH must be a power of two so the pointers wrap naturally.
module arb_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1,
    localparam int CW   = cnt_w(DEPTH),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_push_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == {CW{1'b0}});
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage, pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_push_data;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data LSU, routing in-order responses back.
// Optional macro ARB_RR_EN: alternate priority on conflicts; otherwise data always wins.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    localparam int BE_W           = DATA_W / 8,
    localparam int CW             = cnt_w(MAX_OUTSTANDING)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic              instr_gnt,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_rdata,
    output logic              instr_err,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [BE_W-1:0]   data_be,
    output logic              data_gnt,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_error,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err,
    output logic              spurious_rsp
);

    logic          w_sel_data;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [0:0]    w_head;
    logic [CW-1:0] w_count;
    logic          r_spurious;

`ifdef ARB_RR_EN
    owner_e r_last;
`endif

    // Port selection: a lone requester always wins; conflicts follow the arbitration policy.
    always_comb begin
        w_sel_data = data_req;
`ifdef ARB_RR_EN
        if (instr_req && data_req) begin
            w_sel_data = (r_last == OWN_INSTR);
        end else begin
            w_sel_data = data_req;
        end
`endif
    end

    // Gating with reset_n keeps every grant low while reset is asserted mid-cycle.
    assign mem_req   = (instr_req || data_req) && !w_full && reset_n;
    assign w_push    = mem_req && mem_gnt;
    assign data_gnt  = w_push && w_sel_data;
    assign instr_gnt = w_push && !w_sel_data;

    assign mem_wr    = w_sel_data ? data_wr    : 1'b0;
    assign mem_addr  = w_sel_data ? data_addr  : instr_addr;
    assign mem_wdata = w_sel_data ? data_wdata : {DATA_W{1'b0}};
    assign mem_be    = w_sel_data ? data_be    : {BE_W{1'b1}};

    assign w_pop       = mem_rvalid && !w_empty;
    assign instr_valid = w_pop && (owner_e'(w_head) == OWN_INSTR);
    assign data_valid  = w_pop && (owner_e'(w_head) == OWN_DATA);
    assign instr_rdata = mem_rdata;
    assign data_rdata  = mem_rdata;
    assign instr_err   = mem_err;
    assign data_error  = mem_err;
    assign spurious_rsp = r_spurious;

    arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_sel_data ? 1'(OWN_DATA) : 1'(OWN_INSTR)),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    // Sticky flag for a response arriving with nothing outstanding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_spurious <= 1'b0;
        end else begin
            r_spurious <= r_spurious || (mem_rvalid && (w_count == {CW{1'b0}}));
        end
    end

`ifdef ARB_RR_EN
    // Last-winner pointer moves only when a conflict is actually granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= OWN_INSTR;
        end else if (instr_req && data_req && w_push) begin
            r_last <= w_sel_data ? OWN_DATA : OWN_INSTR;
        end else begin
            r_last <= r_last;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (fixed priority, or round-robin with ARB_RR_EN).
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_valid;
    logic [31:0] instr_rdata;
    logic        instr_err;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_be;
    logic        data_gnt;
    logic        data_valid;
    logic [31:0] data_rdata;
    logic        data_error;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        spurious_rsp;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .instr_req    (instr_req),
        .instr_addr   (instr_addr),
        .instr_gnt    (instr_gnt),
        .instr_valid  (instr_valid),
        .instr_rdata  (instr_rdata),
        .instr_err    (instr_err),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_be      (data_be),
        .data_gnt     (data_gnt),
        .data_valid   (data_valid),
        .data_rdata   (data_rdata),
        .data_error   (data_error),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .mem_err      (mem_err),
        .spurious_rsp (spurious_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        instr_req  = 1'b0;
        instr_addr = 32'h0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_addr  = 32'h0;
        data_wdata = 32'h0;
        data_be    = 4'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        mem_err    = 1'b0;
    endtask

    logic exp_d;
    logic prev_d;

    initial begin
        idle_inputs();
        reset_n    = 1'b0;
        instr_req  = 1'b1;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        settle();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_instr_gnt", 32'(instr_gnt), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_spurious", 32'(spurious_rsp), 32'd0);
        tick();
        idle_inputs();
        reset_n = 1'b1;

        // 1: instruction-only stream, single-cycle responses
        for (int k = 0; k < 4; k++) begin
            tick();
            instr_req  = 1'b1;
            instr_addr = 32'h1000 + 32'(4 * k);
            mem_gnt    = 1'b1;
            mem_rvalid = (k > 0);
            mem_rdata  = 32'h0000_0013;
            settle();
            check("t1_instr_gnt", 32'(instr_gnt), 32'd1);
            check("t1_mem_addr", mem_addr, 32'h1000 + 32'(4 * k));
            check("t1_mem_be", 32'(mem_be), 32'hF);
            check("t1_mem_wr", 32'(mem_wr), 32'd0);
            check("t1_instr_valid", 32'(instr_valid), 32'(k > 0));
            check("t1_data_valid", 32'(data_valid), 32'd0);
            if (k > 0) check("t1_instr_rdata", instr_rdata, 32'h0000_0013);
        end
        tick();
        idle_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0013;
        settle();
        check("t1_drain_valid", 32'(instr_valid), 32'd1);

        // 2: both ports requesting every cycle
        prev_d = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            idle_inputs();
            instr_req  = 1'b1;
            data_req   = 1'b1;
            data_addr  = 32'h2000;
            mem_gnt    = 1'b1;
            mem_rvalid = (k > 0);
`ifdef ARB_RR_EN
            exp_d = (k % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            settle();
            check("t2_data_gnt", 32'(data_gnt), 32'(exp_d));
            check("t2_instr_gnt", 32'(instr_gnt), 32'(!exp_d));
            if (k > 0) begin
                check("t2_data_valid", 32'(data_valid), 32'(prev_d));
                check("t2_instr_valid", 32'(instr_valid), 32'(!prev_d));
            end
            prev_d = exp_d;
        end
        tick();
        idle_inputs();
        mem_rvalid = 1'b1;
        settle();
        check("t2_drain_dvalid", 32'(data_valid), 32'(prev_d));
        check("t2_drain_ivalid", 32'(instr_valid), 32'(!prev_d));

        // 3: no responses, FIFO fills and then frees exactly one slot
        for (int k = 0; k < 2; k++) begin
            tick();
            idle_inputs();
            instr_req = 1'b1;
            mem_gnt   = 1'b1;
            settle();
            check("t3_fill_gnt", 32'(instr_gnt), 32'd1);
        end
        tick();
        data_req = 1'b1;
        settle();
        check("t3_full_req", 32'(mem_req), 32'd0);
        check("t3_full_ignt", 32'(instr_gnt), 32'd0);
        check("t3_full_dgnt", 32'(data_gnt), 32'd0);
        tick();
        mem_rvalid = 1'b1;
        settle();
        check("t3_nobypass_req", 32'(mem_req), 32'd0);
        check("t3_pop_ivalid", 32'(instr_valid), 32'd1);
        tick();
        mem_rvalid = 1'b0;
        settle();
        check("t3_regrant_req", 32'(mem_req), 32'd1);
        check("t3_regrant_dgnt", 32'(data_gnt), 32'd1);
        check("t3_regrant_ignt", 32'(instr_gnt), 32'd0);
        tick();
        settle();
        check("t3_refull_req", 32'(mem_req), 32'd0);
        tick();
        idle_inputs();
        mem_rvalid = 1'b1;
        settle();
        check("t3_drain1_ivalid", 32'(instr_valid), 32'd1);
        check("t3_drain1_dvalid", 32'(data_valid), 32'd0);
        tick();
        settle();
        check("t3_drain2_dvalid", 32'(data_valid), 32'd1);
        check("t3_drain2_ivalid", 32'(instr_valid), 32'd0);

        // 4: store then fetch, responses two cycles later
        tick();
        idle_inputs();
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_addr  = 32'h0000_0100;
        data_wdata = 32'hDEAD_BEEF;
        data_be    = 4'h3;
        mem_gnt    = 1'b1;
        settle();
        check("t4_st_dgnt", 32'(data_gnt), 32'd1);
        check("t4_st_be", 32'(mem_be), 32'h3);
        check("t4_st_wr", 32'(mem_wr), 32'd1);
        check("t4_st_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("t4_st_addr", mem_addr, 32'h0000_0100);
        tick();
        idle_inputs();
        instr_req  = 1'b1;
        instr_addr = 32'h0000_0200;
        mem_gnt    = 1'b1;
        settle();
        check("t4_if_ignt", 32'(instr_gnt), 32'd1);
        check("t4_if_be", 32'(mem_be), 32'hF);
        check("t4_if_wr", 32'(mem_wr), 32'd0);
        check("t4_if_addr", mem_addr, 32'h0000_0200);
        tick();
        idle_inputs();
        mem_rvalid = 1'b1;
        mem_err    = 1'b1;
        settle();
        check("t4_rsp1_dvalid", 32'(data_valid), 32'd1);
        check("t4_rsp1_ivalid", 32'(instr_valid), 32'd0);
        check("t4_rsp1_derr", 32'(data_error), 32'd1);
        tick();
        mem_err   = 1'b0;
        mem_rdata = 32'h0000_0013;
        settle();
        check("t4_rsp2_ivalid", 32'(instr_valid), 32'd1);
        check("t4_rsp2_dvalid", 32'(data_valid), 32'd0);
        check("t4_rsp2_rdata", instr_rdata, 32'h0000_0013);

        // 5: response with nothing outstanding
        tick();
        idle_inputs();
        mem_rvalid = 1'b1;
        settle();
        check("t5_ivalid", 32'(instr_valid), 32'd0);
        check("t5_dvalid", 32'(data_valid), 32'd0);
        check("t5_spur_before", 32'(spurious_rsp), 32'd0);
        tick();
        mem_rvalid = 1'b0;
        settle();
        check("t5_spur_set", 32'(spurious_rsp), 32'd1);
        tick();
        settle();
        check("t5_spur_sticky", 32'(spurious_rsp), 32'd1);

        // 6: reset with two requests in flight
        for (int k = 0; k < 2; k++) begin
            tick();
            idle_inputs();
            instr_req = 1'b1;
            mem_gnt   = 1'b1;
            settle();
            check("t6_fill_gnt", 32'(instr_gnt), 32'd1);
        end
        tick();
        settle();
        check("t6_full_req", 32'(mem_req), 32'd0);
        tick();
        reset_n    = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        check("t6_rst_count", 32'(dut.u_fifo.r_count), 32'd0);
        check("t6_rst_req", 32'(mem_req), 32'd0);
        check("t6_rst_ignt", 32'(instr_gnt), 32'd0);
        check("t6_rst_ivalid", 32'(instr_valid), 32'd0);
        check("t6_rst_spur", 32'(spurious_rsp), 32'd0);
        tick();
        idle_inputs();
        reset_n = 1'b1;
        tick();
        mem_rvalid = 1'b1;
        settle();
        check("t6_post_ivalid", 32'(instr_valid), 32'd0);
        check("t6_post_dvalid", 32'(data_valid), 32'd0);
        tick();
        mem_rvalid = 1'b0;
        settle();
        check("t6_post_spur", 32'(spurious_rsp), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
